filtr_mode_ctrl: RTL and testbench

- Controller and registered datapath for the TV colour-filter stage, placed between the video decoder's RGB output and the VGA pixel path.
- Debounces one push-button that steps through eight channel-permutation/null modes.
- New modes take effect only at a frame boundary (falling edge of iVS), so no frame tears mid-picture.
- Applies the active mode to every pixel with one cycle of latency.

---
 rtl/filtr_mode_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_filtr_mode_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filtr_mode_ctrl.sv
// filtr_mode_ctrl: colour-filter mode controller and one-cycle pixel datapath.
//
// A push-button (iKEY_N) steps through eight channel permutation / null
// modes. Presses are synchronised and debounced. The requested mode is held
// in req_mode and only copied into the active mode (oMODE) on a falling edge
// of iVS, so a frame is never filtered with two different modes.
// iSW[9] forces pass-through (mode 0) at the next frame boundary.
//
// Build option:
//   FILTR_GRAY_EN  when defined, mode 7 outputs grayscale
//                  Y = (R + 2G + B) >> 2 on all three channels. When not
//                  defined, mode 7 nulls blue and no adder is built.
//
// Handshake: there is no backpressure. iDVAL qualifies the input pixel in
// the cycle it is high. oDVAL is iDVAL delayed by one cycle and qualifies
// oRed/oGreen/oBlue, which are forced to 0 whenever oDVAL is low.
//
// Debug: oDBG_STATE exposes the debounce FSM state
//   (0 = released, 1 = press wait, 2 = pressed, 3 = release wait).

module filtr_mode_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int CW         = 10
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iKEY_N,
  input  logic [9:0]    iSW,
  input  logic          iVS,
  input  logic          iDVAL,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic [CW-1:0] oRed,
  output logic [CW-1:0] oGreen,
  output logic [CW-1:0] oBlue,
  output logic          oDVAL,
  output logic [2:0]    oMODE,
  output logic          oPENDING,
  output logic [1:0]    oDBG_STATE
);

  // Counter is wide enough to hold DEB_CYCLES-1 for any legal parameter.
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Debounce FSM encoding.
  localparam logic [1:0] ST_REL   = 2'd0;
  localparam logic [1:0] ST_PWAIT = 2'd1;
  localparam logic [1:0] ST_PRS   = 2'd2;
  localparam logic [1:0] ST_RWAIT = 2'd3;

  // Mode encoding of the datapath.
  localparam logic [2:0] M_PASS   = 3'd0;
  localparam logic [2:0] M_SW_RG  = 3'd1;
  localparam logic [2:0] M_SW_GB  = 3'd2;
  localparam logic [2:0] M_SW_RB  = 3'd3;
  localparam logic [2:0] M_ROT    = 3'd4;
  localparam logic [2:0] M_NULL_R = 3'd5;
  localparam logic [2:0] M_NULL_G = 3'd6;
  localparam logic [2:0] M_LAST   = 3'd7;

  // ---------------------------------------------------------------------
  // Key synchroniser and debounce
  // ---------------------------------------------------------------------
  logic             key_s1;
  logic             key_s2;
  logic             k;
  logic [1:0]       deb_state;
  logic [1:0]       deb_state_nxt;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_cnt_nxt;
  logic             step;

  assign k = key_s2;

  // Two-flop synchroniser; resets to the idle (released, high) level.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= iKEY_N;
      key_s2 <= key_s1;
    end
  end

  // Debounce next-state logic; step fires on the edge that enters PRS.
  always_comb begin
    deb_state_nxt = deb_state;
    deb_cnt_nxt   = deb_cnt;
    step          = 1'b0;
    case (deb_state)
      ST_REL: begin
        if (!k) begin
          deb_cnt_nxt   = '0;
          deb_state_nxt = ST_PWAIT;
        end
      end
      ST_PWAIT: begin
        if (k) begin
          deb_state_nxt = ST_REL;
        end else if (deb_cnt == CNT_LAST) begin
          deb_state_nxt = ST_PRS;
          step          = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      ST_PRS: begin
        if (k) begin
          deb_cnt_nxt   = '0;
          deb_state_nxt = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (!k) begin
          deb_state_nxt = ST_PRS;
        end else if (deb_cnt == CNT_LAST) begin
          deb_state_nxt = ST_REL;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      default: begin
        deb_state_nxt = ST_REL;
        deb_cnt_nxt   = '0;
      end
    endcase
  end

  // Debounce state and counter registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      deb_state <= ST_REL;
      deb_cnt   <= '0;
    end else begin
      deb_state <= deb_state_nxt;
      deb_cnt   <= deb_cnt_nxt;
    end
  end

  assign oDBG_STATE = deb_state;

  // ---------------------------------------------------------------------
  // Mode request and frame-boundary commit
  // ---------------------------------------------------------------------
  logic       vs_prev;
  logic       vs_fall;
  logic       force_pass;
  logic       step_ok;
  logic [2:0] req_mode;
  logic [2:0] eff_req;

  assign vs_fall    = vs_prev & ~iVS;
  assign force_pass = iSW[9];
  assign step_ok    = step & ~force_pass;
  assign eff_req    = force_pass ? M_PASS : req_mode;

  // iSW[8:0] have no function in this block.
  logic unused_sw;
  assign unused_sw = ^iSW[8:0];

  // iVS history for the falling-edge detector; idle level is high.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_prev <= 1'b1;
    end else begin
      vs_prev <= iVS;
    end
  end

  // Request counter: one increment per accepted press, wraps 7 -> 0.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      req_mode <= 3'd0;
    end else if (step_ok) begin
      req_mode <= req_mode + 3'd1;
    end
  end

  // Active mode: takes the pre-increment request on a frame boundary.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMODE <= 3'd0;
    end else if (vs_fall) begin
      oMODE <= eff_req;
    end
  end

  // Pending flag: a new step wins over the frame-boundary clear, so a step
  // landing on vs_fall leaves the freshly incremented request pending.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPENDING <= 1'b0;
    end else if (step_ok) begin
      oPENDING <= 1'b1;
    end else if (vs_fall) begin
      oPENDING <= 1'b0;
    end else if (force_pass) begin
      oPENDING <= (oMODE != M_PASS);
    end
  end

  // ---------------------------------------------------------------------
  // Pixel datapath
  // ---------------------------------------------------------------------
  logic [CW-1:0] red_nxt;
  logic [CW-1:0] green_nxt;
  logic [CW-1:0] blue_nxt;

`ifdef FILTR_GRAY_EN
  logic [CW+1:0] gray_sum;
  logic [CW-1:0] gray_y;

  // R + 2G + B fits in CW+2 bits; the >>2 keeps the top CW bits.
  assign gray_sum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
  assign gray_y   = gray_sum[CW+1:2];
`endif

  // Channel permutation selected by the active mode.
  always_comb begin
    red_nxt   = iRed;
    green_nxt = iGreen;
    blue_nxt  = iBlue;
    case (oMODE)
      M_PASS: begin
        red_nxt   = iRed;
        green_nxt = iGreen;
        blue_nxt  = iBlue;
      end
      M_SW_RG: begin
        red_nxt   = iGreen;
        green_nxt = iRed;
      end
      M_SW_GB: begin
        green_nxt = iBlue;
        blue_nxt  = iGreen;
      end
      M_SW_RB: begin
        red_nxt  = iBlue;
        blue_nxt = iRed;
      end
      M_ROT: begin
        red_nxt   = iGreen;
        green_nxt = iBlue;
        blue_nxt  = iRed;
      end
      M_NULL_R: begin
        red_nxt = '0;
      end
      M_NULL_G: begin
        green_nxt = '0;
      end
      M_LAST: begin
`ifdef FILTR_GRAY_EN
        red_nxt   = gray_y;
        green_nxt = gray_y;
        blue_nxt  = gray_y;
`else
        blue_nxt = '0;
`endif
      end
      default: begin
        red_nxt   = iRed;
        green_nxt = iGreen;
        blue_nxt  = iBlue;
      end
    endcase
  end

  // Output pixel register; invalid input cycles load zeros.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oDVAL  <= 1'b0;
    end else begin
      oDVAL <= iDVAL;
      if (iDVAL) begin
        oRed   <= red_nxt;
        oGreen <= green_nxt;
        oBlue  <= blue_nxt;
      end else begin
        oRed   <= '0;
        oGreen <= '0;
        oBlue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_filtr_mode_ctrl.sv
// Testbench for filtr_mode_ctrl: vector table, hand-written multi-cycle
// sequences and randomized pixel traffic against a mode-level model.
`timescale 1ns/1ps

module tb_filtr_mode_ctrl;

  localparam int CW  = 10;
  localparam int DEB = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_n = 1'b1;
  logic [9:0]    sw = '0;
  logic          vs = 1'b1;
  logic          dval = 1'b0;
  logic [CW-1:0] r_in = '0;
  logic [CW-1:0] g_in = '0;
  logic [CW-1:0] b_in = '0;
  logic [CW-1:0] r_out;
  logic [CW-1:0] g_out;
  logic [CW-1:0] b_out;
  logic          dval_out;
  logic [2:0]    mode_out;
  logic          pending_out;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  filtr_mode_ctrl #(.DEB_CYCLES(DEB), .CW(CW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iKEY_N(key_n), .iSW(sw), .iVS(vs),
    .iDVAL(dval), .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
    .oRed(r_out), .oGreen(g_out), .oBlue(b_out), .oDVAL(dval_out),
    .oMODE(mode_out), .oPENDING(pending_out), .oDBG_STATE(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;

  // Mode-level model: what has been requested and what is active.
  int m_req = 0;
  int m_mode = 0;
  bit m_pending = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected filtered pixel from the mode rules.
  task automatic exp_pix(input int m, input logic [CW-1:0] r, input logic [CW-1:0] g,
                         input logic [CW-1:0] b, input logic dv,
                         output logic [CW-1:0] er, output logic [CW-1:0] eg,
                         output logic [CW-1:0] eb);
    int y;
    er = r; eg = g; eb = b;
    case (m)
      1: begin er = g; eg = r; end
      2: begin eg = b; eb = g; end
      3: begin er = b; eb = r; end
      4: begin er = g; eg = b; eb = r; end
      5: er = '0;
      6: eg = '0;
      7: begin
`ifdef FILTR_GRAY_EN
        y = (int'(r) + 2 * int'(g) + int'(b)) / 4;
        er = CW'(y); eg = CW'(y); eb = CW'(y);
`else
        eb = '0;
`endif
      end
      default: ;
    endcase
    if (!dv) begin
      er = '0; eg = '0; eb = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_n = 1'b1; vs = 1'b1; dval = 1'b0; sw = '0;
    m_req = 0; m_mode = 0; m_pending = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_red", r_out, 0);
    chk("rst_green", g_out, 0);
    chk("rst_blue", b_out, 0);
    chk("rst_dval", dval_out, 0);
    chk("rst_mode", mode_out, 0);
    chk("rst_pending", pending_out, 0);
    chk("rst_dbg_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One clean press and release, long enough to be accepted.
  task automatic press();
    @(negedge clk);
    key_n = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    key_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    if (sw[9]) begin
      m_pending = (m_mode != 0);
    end else begin
      m_req = (m_req + 1) % 8;
      m_pending = 1'b1;
    end
    chk("press_pending", pending_out, m_pending);
    chk("press_mode_held", mode_out, m_mode);
  endtask

  // One iVS low pulse; the active mode updates on its falling edge.
  task automatic frame();
    @(negedge clk);
    chk("pre_vs_mode", mode_out, m_mode);
    vs = 1'b0;
    @(posedge clk);
    #1;
    m_mode = sw[9] ? 0 : m_req;
    m_pending = 1'b0;
    chk("vs_mode", mode_out, m_mode);
    chk("vs_pending", pending_out, m_pending);
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic goto_mode(input int m);
    while (m_mode != m) begin
      press();
      frame();
    end
  endtask

  // Drive one pixel and check it one cycle later.
  task automatic pixel(input logic [CW-1:0] r, input logic [CW-1:0] g,
                       input logic [CW-1:0] b, input logic dv, input string name);
    logic [CW-1:0] er, eg, eb;
    @(negedge clk);
    r_in = r; g_in = g; b_in = b; dval = dv;
    exp_pix(m_mode, r, g, b, dv, er, eg, eb);
    @(posedge clk);
    #1;
    chk({name, "_red"}, r_out, er);
    chk({name, "_green"}, g_out, eg);
    chk({name, "_blue"}, b_out, eb);
    chk({name, "_dval"}, dval_out, dv);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            mode;
    logic [CW-1:0] r, g, b;
    logic          dv;
    logic [CW-1:0] er, eg, eb;
  } vec_t;

  vec_t tbl[$];

  // ---------------- main sequence ----------------
  initial begin
    tbl.push_back('{0, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h3FF, 10'h155, 10'h0AA});
    tbl.push_back('{0, 10'h001, 10'h200, 10'h3FE, 1'b1, 10'h001, 10'h200, 10'h3FE});
    tbl.push_back('{1, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h155, 10'h3FF, 10'h0AA});
    tbl.push_back('{2, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h3FF, 10'h0AA, 10'h155});
    tbl.push_back('{2, 10'h3FF, 10'h155, 10'h0AA, 1'b0, 10'h000, 10'h000, 10'h000});
    tbl.push_back('{3, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h0AA, 10'h155, 10'h3FF});
    tbl.push_back('{4, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h155, 10'h0AA, 10'h3FF});
    tbl.push_back('{5, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h000, 10'h155, 10'h0AA});
    tbl.push_back('{6, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h3FF, 10'h000, 10'h0AA});
`ifdef FILTR_GRAY_EN
    tbl.push_back('{7, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h1D4, 10'h1D4, 10'h1D4});
    tbl.push_back('{7, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF});
    tbl.push_back('{7, 10'h100, 10'h000, 10'h100, 1'b1, 10'h080, 10'h080, 10'h080});
`else
    tbl.push_back('{7, 10'h3FF, 10'h155, 10'h0AA, 1'b1, 10'h3FF, 10'h155, 10'h000});
    tbl.push_back('{7, 10'h100, 10'h000, 10'h100, 1'b1, 10'h100, 10'h000, 10'h000});
`endif

    // Reset state and table of per-mode vectors.
    do_reset();
    foreach (tbl[i]) begin
      goto_mode(tbl[i].mode);
      @(negedge clk);
      r_in = tbl[i].r; g_in = tbl[i].g; b_in = tbl[i].b; dval = tbl[i].dv;
      @(posedge clk);
      #1;
      chk("tbl_red", r_out, tbl[i].er);
      chk("tbl_green", g_out, tbl[i].eg);
      chk("tbl_blue", b_out, tbl[i].eb);
      chk("tbl_dval", dval_out, tbl[i].dv);
      chk("tbl_mode", mode_out, tbl[i].mode);
    end

    // Bounced short press: no step.
    do_reset();
    begin
      int low_cycles = 0;
      while (low_cycles < DEB / 2) begin
        @(negedge clk); key_n = 1'b0;
        repeat (3) @(negedge clk);
        low_cycles += 3;
        key_n = 1'b1;
        @(negedge clk);
      end
      key_n = 1'b1;
      repeat (DEB + 6) @(negedge clk);
      chk("bounce_pending", pending_out, 0);
      chk("bounce_mode", mode_out, 0);
    end
    // Long press: pending, mode held until the frame boundary.
    press();
    chk("long_press_pending", pending_out, 1);
    chk("long_press_mode_held", mode_out, 0);
    frame();
    chk("first_step_mode", mode_out, 1);
    pixel(10'h3FF, 10'h155, 10'h0AA, 1'b1, "mode1_pix");

    // Wrap: eight presses from reset give 1..7 then 0.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press();
      frame();
      chk("wrap_seq", mode_out, i % 8);
    end

    // Step pulse coincident with the iVS falling edge.
    do_reset();
    press();
    press();
    @(negedge clk);
    key_n = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    vs = 1'b0;
    @(posedge clk);
    #1;
    chk("coinc_mode", mode_out, 2);
    chk("coinc_pending", pending_out, 1);
    m_mode = 2; m_req = 3; m_pending = 1'b1;
    repeat (4) @(negedge clk);
    key_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    frame();
    chk("coinc_req_after", mode_out, 3);

    // Forced pass-through via iSW[9].
    do_reset();
    goto_mode(5);
    @(negedge clk);
    sw = 10'h200;
    @(posedge clk);
    #1;
    chk("force_pending", pending_out, 1);
    chk("force_mode_held", mode_out, 5);
    frame();
    chk("force_mode0", mode_out, 0);
    press();
    chk("force_press_ignored_pending", pending_out, 0);
    frame();
    chk("force_press_ignored_mode", mode_out, 0);

    // Mid-frame reset.
    do_reset();
    goto_mode(3);
    pixel(10'h3FF, 10'h155, 10'h0AA, 1'b1, "pre_rst");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_red", r_out, 0);
    chk("midrst_blue", b_out, 0);
    chk("midrst_dval", dval_out, 0);
    chk("midrst_mode", mode_out, 0);
    m_req = 0; m_mode = 0; m_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pixel(10'h3FF, 10'h155, 10'h0AA, 1'b1, "post_rst");

    // Randomized pixels across random mode sequences.
    do_reset();
    repeat (6) begin
      int n = $urandom_range(1, 3);
      repeat (n) press();
      frame();
      repeat (40) begin
        pixel(CW'($urandom_range(0, (1 << CW) - 1)), CW'($urandom_range(0, (1 << CW) - 1)),
              CW'($urandom_range(0, (1 << CW) - 1)), ($urandom_range(0, 3) != 0), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
